seq_det_sched: RTL and testbench
================================

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter NCH, default 4, number of serial bit channels sharing one pattern-detector next-state engine (legal range 2..8).
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  NCH  per-channel request; bit i high means channel i presents a bit on w[i].
REQ-005 w  input  NCH  per-channel data bit; held stable by the requester while req[i] is high and gnt[i] is low.
REQ-006 clr  input  NCH  per-channel context clear to state A.
REQ-007 gnt  output  NCH  one-hot-or-zero grant, combinational from req, clr and the round-robin pointer; the bit is consumed at the clock edge ending the grant cycle.
REQ-008 out_valid  output  1  registered; high for one cycle after each grant.
REQ-009 out_ch  output  clog2(NCH)  registered index of the channel reported by out_valid.
REQ-010 out_z  output  1  registered; detector output of the updated channel state.
REQ-011 z_vec  output  NCH  per-channel detector output taken directly from the context registers.

Function
REQ-012 Each channel SHALL own a 3-bit context register holding one of A..F; one shared next-state engine SHALL serve the channels.
REQ-013 Transitions SHALL be: A: w?B:A; B: w?C:D; C: w?E:D; D: w?F:A; E: w?E:D; F: w?C:D.
REQ-014 Detector output z SHALL be 1 exactly when the state is E or F.
REQ-015 The block SHALL grant at most one channel per cycle, round-robin, searching upward from the index after the last granted channel and wrapping from NCH-1 to 0.
REQ-016 A channel with clr[i] high SHALL NOT be granted that cycle; its context SHALL become A at the edge, and its pending bit SHALL remain pending.
REQ-017 On grant of channel i in cycle t, the context of i SHALL take the next state at the end of t; in t+1 out_valid=1, out_ch=i, out_z=z(next state), and z_vec[i] SHALL reflect the new state.
REQ-018 In cycles with no grant, out_valid SHALL be 0; out_ch and out_z SHALL hold their previous values.
REQ-019 Ungranted channels SHALL keep their context unchanged.
REQ-020 With a single active requester, the block SHALL grant it every cycle (full throughput, no bubbles).
REQ-021 An undefined context encoding (6 or 7) SHALL be treated as A.

Reset
REQ-022 While reset is high at an edge, all contexts SHALL become A, the pointer SHALL select channel 0 as the next grant, and out_valid, out_ch and out_z SHALL become 0.
REQ-023 gnt SHALL be all-zero while reset is high; a bit presented during reset SHALL be neither consumed nor reported.

Configuration
REQ-024 With SEQ_DET_SCHED_STATS_EN defined, output hit_cnt (NCH*16, channel i at bits [16i+15:16i]) SHALL count, saturating at 0xFFFF, each update that moves channel i from a non-E/F state into E or F; reset or clr[i] SHALL zero the count.
REQ-025 Without SEQ_DET_SCHED_STATS_EN, the hit_cnt port and its counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-026 Package seq_det_sched_pkg SHALL hold the state typedef (A=0..F=5) and the next-state and z functions.
REQ-027 The round-robin grant logic SHALL be a sub-module named rr_arb (parameter N, inputs req, last-grant pointer, output one-hot gnt).

Verification
REQ-028 Reset, then req=4'b0001 with w[0] sequence 1,1,1 -> out_z 0,0,1 on successive out_valid cycles; z_vec[0]=1 after the third bit.
REQ-029 req=4'b1111 held for 8 cycles -> gnt order 0,1,2,3,0,1,2,3; out_ch follows it one cycle later.
REQ-030 Channel 2 fed 1,0,1 (ending in F, z=1) interleaved with channel 1 fed 0s -> z_vec=4'b0100; channel 1 context stays A.
REQ-031 req=4'b0011 and clr=4'b0001 in the same cycle -> gnt=4'b0010; channel 0 context becomes A; channel 0 granted next cycle.
REQ-032 Channel 3 driven to E, reset asserted mid-stream for 1 cycle -> z_vec=0, out_valid=0, first grant after reset goes to the lowest requesting index.
REQ-033 With SEQ_DET_SCHED_STATS_EN, channel 0 fed 1,1,1,0,1,1 -> hit_cnt[15:0]=2 (A->B->C->E, then D->F, then F->C without increment).

Source files
------------

// File: rtl/seq_det_sched_pkg.sv
// Shared definitions for seq_det_sched: detector state encoding plus the
// next-state and output functions used by the time-shared engine.
package seq_det_sched_pkg;

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } state_t;

  // Encodings 6 and 7 fall into the default arm and behave like A.
  function automatic state_t next_state(input logic [2:0] s, input logic w);
    state_t n;
    case (s)
      ST_B:    n = w ? ST_C : ST_D;
      ST_C:    n = w ? ST_E : ST_D;
      ST_D:    n = w ? ST_F : ST_A;
      ST_E:    n = w ? ST_E : ST_D;
      ST_F:    n = w ? ST_C : ST_D;
      default: n = w ? ST_B : ST_A;
    endcase
    return n;
  endfunction

  function automatic logic is_hit(input logic [2:0] s);
    return (s == ST_E) || (s == ST_F);
  endfunction

endpackage

// File: rtl/seq_det_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester found searching upward
// from the slot after the last grant, wrapping from N-1 to 0.
module rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt
);

  localparam int LW = $clog2(N);

  logic [LW-1:0] idx;
  logic          found;

  // Rotating priority search; k=N revisits 'last' itself as lowest priority.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = LW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Multi-channel pattern detector: NCH per-channel context registers served
// by one shared next-state engine, with one round-robin grant per cycle.
// Optional feature: define SEQ_DET_SCHED_STATS_EN for per-channel hit
// counters on the hit_cnt port.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req,
  input  logic [NCH-1:0]          w,
  input  logic [NCH-1:0]          clr,
  output logic [NCH-1:0]          gnt,
  output logic                    out_valid,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic                    out_z,
  output logic [NCH-1:0]          z_vec
`ifdef SEQ_DET_SCHED_STATS_EN
  ,
  output logic [NCH*16-1:0]       hit_cnt
`endif
);

  localparam int IW = $clog2(NCH);

  logic [2:0]     ctx   [NCH];
  logic [2:0]     ctx_d [NCH];
  logic [IW-1:0]  last_ptr;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  gidx;
  logic [2:0]     eng_nxt;
  logic           any_gnt;

  // Cleared channels sit out this cycle; their bit stays pending.
  assign elig = req & ~clr;

  rr_arb #(.N(NCH)) u_arb (
    .req  (elig),
    .last (last_ptr),
    .gnt  (arb_gnt)
  );

  assign gnt     = reset ? '0 : arb_gnt;
  assign any_gnt = |gnt;

  // Shared engine: pick the granted channel's context and compute its next state.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt[i]) gidx = IW'(i);
    end
    eng_nxt = next_state(ctx[gidx], w[gidx]);
    for (int unsigned i = 0; i < NCH; i++) begin
      ctx_d[i] = ctx[i];
      if (clr[i])      ctx_d[i] = ST_A;
      else if (gnt[i]) ctx_d[i] = eng_nxt;
    end
  end

  // Context, pointer and report registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) ctx[i] <= ST_A;
      last_ptr  <= IW'(NCH - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_z     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) ctx[i] <= ctx_d[i];
      out_valid <= any_gnt;
      if (any_gnt) begin
        last_ptr <= gidx;
        out_ch   <= gidx;
        out_z    <= is_hit(eng_nxt);
      end
    end
  end

  // Per-channel detector output straight from the context registers.
  always_comb begin
    z_vec = '0;
    for (int unsigned i = 0; i < NCH; i++) z_vec[i] = is_hit(ctx[i]);
  end

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [15:0] hits [NCH];

  // Count entries into E/F per channel, saturating at all-ones.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (reset || clr[i]) begin
        hits[i] <= '0;
      end else if (gnt[i] && !is_hit(ctx[i]) && is_hit(eng_nxt) && (hits[i] != '1)) begin
        hits[i] <= hits[i] + 16'd1;
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < NCH; i++) hit_cnt[16*i +: 16] = hits[i];
  end
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed self-checking bench for seq_det_sched (NCH=4).
module tb_seq_det_sched;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_z;
  logic [3:0] z_vec;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [63:0] hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  seq_det_sched #(.NCH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .w         (w),
    .clr       (clr),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_z     (out_z),
    .z_vec     (z_vec)
`ifdef SEQ_DET_SCHED_STATS_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; w = '0; clr = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; w = 4'b1111; clr = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    checks++; if (out_z !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", out_z); end
    checks++; if (z_vec !== 4'b0000) begin errors++; $display("FAIL reset_zvec got=%b exp=0000", z_vec); end
    reset = 1'b0; req = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_noconsume got=%b exp=0", out_valid); end
    checks++; if (z_vec !== 4'b0000) begin errors++; $display("FAIL reset_zvec2 got=%b exp=0000", z_vec); end
  endtask

  task automatic test_single();
    logic ez [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    req = 4'b0001; w = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt%0d got=%b exp=0001", k, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin errors++; $display("FAIL single_rep%0d got=%b/%0d exp=1/0", k, out_valid, out_ch); end
      checks++; if (out_z !== ez[k]) begin errors++; $display("FAIL single_z%0d got=%b exp=%b", k, out_z, ez[k]); end
    end
    checks++; if (z_vec !== 4'b0001) begin errors++; $display("FAIL single_zvec got=%b exp=0001", z_vec); end
    req = '0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_z !== 1'b1 || out_ch !== 2'd0) begin
      errors++; $display("FAIL idle_hold got=%b/%b/%0d exp=0/1/0", out_valid, out_z, out_ch);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    req = 4'b1111; w = '0;
    for (int k = 0; k < 8; k++) begin
      eg = 4'b0001 << (k % 4);
      #1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, eg); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(k % 4)) begin
        errors++; $display("FAIL rr_ch%0d got=%b/%0d exp=1/%0d", k, out_valid, out_ch, k % 4);
      end
    end
  endtask

  task automatic test_interleave();
    logic b2 [3] = '{1'b1, 1'b0, 1'b1};
    logic ez [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] eg;
    int n2 = 0;
    do_reset();
    req = 4'b0110; w = '0;
    for (int k = 0; k < 6; k++) begin
      w[1] = 1'b0;
      w[2] = b2[n2];
      eg = (k % 2 == 0) ? 4'b0010 : 4'b0100;
      #1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL il_gnt%0d got=%b exp=%b", k, gnt, eg); end
      tick();
      if (k % 2 == 1 && n2 < 2) n2++;
    end
    checks++; if (z_vec !== 4'b0100) begin errors++; $display("FAIL il_zvec got=%b exp=0100", z_vec); end
    checks++; if (out_ch !== 2'd2 || out_z !== 1'b1) begin errors++; $display("FAIL il_last got=%0d/%b exp=2/1", out_ch, out_z); end
    // channel 1 must still be in A: 1,1,1 reaches E only on the third bit
    req = 4'b0010; w = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_ch !== 2'd1 || out_z !== ez[k]) begin
        errors++; $display("FAIL il_ch1_z%0d got=%0d/%b exp=1/%b", k, out_ch, out_z, ez[k]);
      end
    end
    checks++; if (z_vec !== 4'b0110) begin errors++; $display("FAIL il_zvec2 got=%b exp=0110", z_vec); end
  endtask

  task automatic test_clr();
    do_reset();
    req = 4'b0001; w = 4'b0001;
    tick(); tick();                 // ch0: A->B->C
    req = 4'b0010; w = 4'b0000;
    tick();                         // ch1 granted, pointer now 1
    req = 4'b0011; w = 4'b0001; clr = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL clr_gnt got=%b exp=0010", gnt); end
    tick();
    checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL clr_ch got=%0d exp=1", out_ch); end
    clr = '0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL clr_next_gnt got=%b exp=0001", gnt); end
    tick();
    // cleared to A then w=1 -> B (z=0); without the clear C->E would give z=1
    checks++; if (out_ch !== 2'd0 || out_z !== 1'b0) begin errors++; $display("FAIL clr_ctx got=%0d/%b exp=0/0", out_ch, out_z); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000; w = 4'b1000;
    tick(); tick(); tick();
    checks++; if (z_vec !== 4'b1000 || out_z !== 1'b1) begin errors++; $display("FAIL rm_pre got=%b/%b exp=1000/1", z_vec, out_z); end
    reset = 1'b1; req = 4'b1010; w = 4'b1010;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rm_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (z_vec !== 4'b0000 || out_valid !== 1'b0 || out_ch !== 2'd0 || out_z !== 1'b0) begin
      errors++; $display("FAIL rm_state got=%b/%b/%0d/%b exp=0000/0/0/0", z_vec, out_valid, out_ch, out_z);
    end
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_first got=%b exp=0010", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin errors++; $display("FAIL rm_rep got=%b/%0d exp=1/1", out_valid, out_ch); end
    req = '0;
  endtask

`ifdef SEQ_DET_SCHED_STATS_EN
  task automatic test_stats();
    logic bits [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      w = {3'b000, bits[k]};
      tick();
    end
    checks++; if (hit_cnt[15:0] !== 16'd2) begin errors++; $display("FAIL stats_cnt got=%0d exp=2", hit_cnt[15:0]); end
    checks++; if (hit_cnt[63:16] !== 48'd0) begin errors++; $display("FAIL stats_other got=%h exp=0", hit_cnt[63:16]); end
    req = '0; clr = 4'b0001;
    tick();
    clr = '0;
    checks++; if (hit_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stats_clr got=%0d exp=0", hit_cnt[15:0]); end
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; w = '0; clr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_interleave();
    test_clr();
    test_reset_mid();
`ifdef SEQ_DET_SCHED_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
